// File: rtl/lod_param_fetch.sv
// ============================================================================
// lod_param_fetch : fetches one octree's position + per-level delta-L record
//                   from the LOD SRAM and hands it to the LOD compute stage.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module lod_param_fetch #(
    parameter int DIMENTION      = 3,
    parameter int DATA_WIDTH     = 16,
    parameter int DATA_BUS_WIDTH = 64,
    parameter int ADDR_BUS_WIDTH = 64,
    parameter int TREE_LEVEL     = 8,
    parameter int LOD_START_ADDR = 1,
    parameter int NUM_TREES      = 1024
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  fetch_start_i,
    input  logic [DATA_WIDTH-1:0]                 tree_idx_i,
    input  logic                                  fetch_abort_i,
    output logic                                  fetch_busy_o,
    output logic                                  fetch_err_o,
    output logic                                  params_valid_o,
    input  logic                                  params_ready_i,
    output logic [DIMENTION-1:0][DATA_WIDTH-1:0]  tree_pos_o,
    output logic [TREE_LEVEL-1:0][DATA_WIDTH-1:0] delta_l_o,
    output logic                                  mem_sram_CEN_o,
    output logic [ADDR_BUS_WIDTH-1:0]             mem_sram_A_o,
    output logic [DATA_BUS_WIDTH-1:0]             mem_sram_D_o,
    output logic                                  mem_sram_GWEN_o,
    input  logic [DATA_BUS_WIDTH-1:0]             mem_sram_Q_i
);

    if (DIMENTION != 3) begin : g_chk_dim
        $error("lod_param_fetch: DIMENTION must be 3");
    end
    if (DATA_WIDTH != 16) begin : g_chk_dw
        $error("lod_param_fetch: DATA_WIDTH must be 16");
    end
    if (DATA_BUS_WIDTH != 64) begin : g_chk_bus
        $error("lod_param_fetch: DATA_BUS_WIDTH must be 64");
    end
    if (TREE_LEVEL != 8) begin : g_chk_lvl
        $error("lod_param_fetch: TREE_LEVEL must be 8");
    end

    localparam logic [ADDR_BUS_WIDTH-1:0] c_ADDR_ONE = ADDR_BUS_WIDTH'(1);
    localparam logic [ADDR_BUS_WIDTH-1:0] c_ADDR_TWO = ADDR_BUS_WIDTH'(2);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD0  = 3'd1,
        S_RD1  = 3'd2,
        S_RD2  = 3'd3,
        S_LAST = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t                                state_q;
    logic [ADDR_BUS_WIDTH-1:0]             base_q;
    logic [ADDR_BUS_WIDTH-1:0]             addr_q;
    logic [DATA_WIDTH-1:0]                 pend_idx_q;
    logic [DATA_WIDTH-1:0]                 cache_idx_q;
    logic                                  cache_vld_q;
    logic                                  busy_q;
    logic                                  err_q;
    logic                                  valid_q;
    logic                                  cen_q;
    logic [DIMENTION-1:0][DATA_WIDTH-1:0]  pos_q;
    logic [TREE_LEVEL-1:0][DATA_WIDTH-1:0] dl_q;

    logic [ADDR_BUS_WIDTH-1:0] base_d;
    logic                      idx_oor;
    logic                      cache_hit;

    // Record address wraps modulo the address bus width.
    assign base_d    = ADDR_BUS_WIDTH'(LOD_START_ADDR)
                     + ADDR_BUS_WIDTH'(tree_idx_i) * ADDR_BUS_WIDTH'(3);
    assign idx_oor   = 32'(tree_idx_i) >= NUM_TREES;
    assign cache_hit = cache_vld_q && (tree_idx_i == cache_idx_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            addr_q      <= '0;
            pend_idx_q  <= '0;
            cache_idx_q <= '0;
            cache_vld_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            valid_q     <= 1'b0;
            cen_q       <= 1'b1;
            pos_q       <= '0;
            dl_q        <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (fetch_abort_i) begin
                        cache_vld_q <= 1'b0;
                    end else if (fetch_start_i) begin
                        if (idx_oor) begin
                            err_q <= 1'b1;
                        end else if (cache_hit) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b1;
                        end else begin
                            base_q     <= base_d;
                            pend_idx_q <= tree_idx_i;
                            state_q    <= S_RD0;
                            busy_q     <= 1'b1;
                        end
                    end
                end
                S_RD0, S_RD1, S_RD2, S_LAST: begin
                    if (fetch_abort_i) begin
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                        cen_q       <= 1'b1;
                        cache_vld_q <= 1'b0;
                    end else begin
                        case (state_q)
                            S_RD0: begin
                                cen_q   <= 1'b0;
                                addr_q  <= base_q;
                                state_q <= S_RD1;
                            end
                            S_RD1: begin
                                addr_q   <= base_q + c_ADDR_ONE;
                                pos_q[0] <= mem_sram_Q_i[63:48];
                                pos_q[1] <= mem_sram_Q_i[47:32];
                                pos_q[2] <= mem_sram_Q_i[31:16];
                                dl_q[0]  <= mem_sram_Q_i[15:0];
                                state_q  <= S_RD2;
                            end
                            S_RD2: begin
                                addr_q  <= base_q + c_ADDR_TWO;
                                dl_q[1] <= mem_sram_Q_i[63:48];
                                dl_q[2] <= mem_sram_Q_i[47:32];
                                dl_q[3] <= mem_sram_Q_i[31:16];
                                dl_q[4] <= mem_sram_Q_i[15:0];
                                state_q <= S_LAST;
                            end
                            default: begin
                                // Low 16 bits of the third word are padding.
                                cen_q       <= 1'b1;
                                dl_q[5]     <= mem_sram_Q_i[63:48];
                                dl_q[6]     <= mem_sram_Q_i[47:32];
                                dl_q[7]     <= mem_sram_Q_i[31:16];
                                cache_idx_q <= pend_idx_q;
                                cache_vld_q <= 1'b1;
                                state_q     <= S_DONE;
                            end
                        endcase
                    end
                end
                S_DONE: begin
                    if (fetch_abort_i) begin
                        valid_q <= 1'b0;
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (!valid_q) begin
                        valid_q <= 1'b1;
                    end else if (params_ready_i) begin
                        valid_q <= 1'b0;
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    cen_q   <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign fetch_busy_o    = busy_q;
    assign fetch_err_o     = err_q;
    assign params_valid_o  = valid_q;
    assign tree_pos_o      = pos_q;
    assign delta_l_o       = dl_q;
    assign mem_sram_CEN_o  = cen_q;
    assign mem_sram_A_o    = addr_q;
    assign mem_sram_D_o    = '0;
    assign mem_sram_GWEN_o = 1'b1;

endmodule

`default_nettype wire

// File: tb/tb_lod_param_fetch.sv
// ============================================================================
// tb_lod_param_fetch : randomized scoreboard bench for lod_param_fetch.
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_lod_param_fetch;

    localparam int NTREES = 1024;
    localparam int START  = 1;

    typedef struct packed {
        logic [2:0][15:0] pos;
        logic [7:0][15:0] dl;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [15:0]       idx;
    logic              abort;
    logic              busy;
    logic              err;
    logic              valid;
    logic              ready;
    logic [2:0][15:0]  tp;
    logic [7:0][15:0]  dl;
    logic              sram_cen;
    logic [63:0]       sram_a;
    logic [63:0]       sram_d;
    logic              sram_gwen;
    logic [63:0]       sram_q;

    logic [63:0] mem [0:4095];

    exp_t        sb_q[$];
    logic [63:0] addr_log[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        model_valid;
    int          model_idx;

    always #5 clk = ~clk;

    assign sram_q = sram_cen ? 64'hDEAD_BEEF_DEAD_BEEF : mem[sram_a[11:0]];

    lod_param_fetch #(
        .NUM_TREES      (NTREES),
        .LOD_START_ADDR (START)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fetch_start_i   (start),
        .tree_idx_i      (idx),
        .fetch_abort_i   (abort),
        .fetch_busy_o    (busy),
        .fetch_err_o     (err),
        .params_valid_o  (valid),
        .params_ready_i  (ready),
        .tree_pos_o      (tp),
        .delta_l_o       (dl),
        .mem_sram_CEN_o  (sram_cen),
        .mem_sram_A_o    (sram_a),
        .mem_sram_D_o    (sram_d),
        .mem_sram_GWEN_o (sram_gwen),
        .mem_sram_Q_i    (sram_q)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Record = 12 fp16 fields, MSB first across three words: x,y,z,dl0..dl7,pad.
    function automatic exp_t model_params(input int t);
        exp_t        r;
        logic [63:0] w;
        logic [15:0] f [12];
        for (int k = 0; k < 12; k++) begin
            w    = mem[START + 3 * t + k / 4];
            f[k] = 16'(w >> (48 - 16 * (k % 4)));
        end
        for (int j = 0; j < 3; j++) r.pos[j] = f[j];
        for (int i = 0; i < 8; i++) r.dl[i] = f[3 + i];
        return r;
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_cen"},   sram_cen,  1'b1);
        chk({tag, "_addr"},  sram_a,    64'd0);
        chk({tag, "_d"},     sram_d,    64'd0);
        chk({tag, "_gwen"},  sram_gwen, 1'b1);
        chk({tag, "_busy"},  busy,      1'b0);
        chk({tag, "_err"},   err,       1'b0);
        chk({tag, "_valid"}, valid,     1'b0);
        chk({tag, "_pos"},   tp,        48'd0);
        chk({tag, "_dl"},    dl,        128'd0);
    endtask

    // One fetch from IDLE with `bp` cycles of backpressure once params are valid.
    task automatic do_fetch(input int t, input int bp);
        exp_t e;
        bit   is_err;
        bit   is_hit;
        int   lat;
        int   base;
        is_err = (t >= NTREES);
        is_hit = !is_err && model_valid && (model_idx == t);
        base   = START + 3 * t;
        addr_log.delete();
        start  = 1'b1;
        idx    = 16'(t);
        if (!is_err) begin
            e = model_params(t);
            sb_q.push_back(e);
        end
        tick();
        start = 1'b0;
        if (is_err) begin
            chk("err_pulse", err, 1'b1);
            chk("err_busy", busy, 1'b0);
            tick();
            chk("err_clear", err, 1'b0);
            chk("err_no_sram", addr_log.size(), 0);
            return;
        end
        lat = 0;
        while (!valid && lat < 20) begin
            tick();
            lat++;
        end
        chk(is_hit ? "hit_latency" : "miss_latency", lat, is_hit ? 1 : 5);
        for (int c = 0; c < bp; c++) begin
            chk("bp_valid", valid, 1'b1);
            chk("bp_pos", tp, e.pos);
            chk("bp_dl", dl, e.dl);
            tick();
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("post_xfer_valid", valid, 1'b0);
        chk("post_xfer_busy", busy, 1'b0);
        if (is_hit) begin
            chk("hit_no_sram", addr_log.size(), 0);
        end else begin
            chk("miss_nreads", addr_log.size(), 3);
            for (int k = 0; k < addr_log.size() && k < 3; k++)
                chk("miss_addr", addr_log[k], 64'(base + k));
            model_valid = 1'b1;
            model_idx   = t;
        end
        addr_log.delete();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (!sram_cen) begin
                addr_log.push_back(sram_a);
                chk("cen_only_when_busy", busy, 1'b1);
            end
            if (valid && ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_transfer: got params_valid=1 expected no pending fetch");
                end else begin
                    e = sb_q.pop_front();
                    chk("payload_pos", tp, e.pos);
                    chk("payload_dl", dl, e.dl);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected $finish before time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        rst_n       = 1'b0;
        start       = 1'b0;
        idx         = '0;
        abort       = 1'b0;
        ready       = 1'b0;
        model_valid = 1'b0;
        model_idx   = 0;
        for (int a = 0; a < 4096; a++) mem[a] = {$urandom, $urandom};
        mem[16] = 64'h3C00_4000_4200_0010;
        mem[17] = 64'h0011_0012_0013_0014;
        mem[18] = 64'h0015_0016_0017_0000;

        repeat (3) tick();
        check_reset("reset");
        rst_n = 1'b1;
        tick();

        // Miss with backpressure, then hit on the same tree.
        do_fetch(5, 10);
        chk("tree5_pos", tp, {16'h4200, 16'h4000, 16'h3C00});
        chk("tree5_dl", dl, {16'h0017, 16'h0016, 16'h0015, 16'h0014,
                             16'h0013, 16'h0012, 16'h0011, 16'h0010});
        do_fetch(5, 2);

        // Out of range index.
        do_fetch(NTREES, 0);

        // Abort in RD1 for tree 7.
        addr_log.delete();
        start = 1'b1;
        idx   = 16'd7;
        tick();
        start = 1'b0;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_valid", valid, 1'b0);
        chk("abort_cen", sram_cen, 1'b1);
        tick();
        chk("abort_valid_later", valid, 1'b0);
        chk("abort_nreads", addr_log.size(), 1);
        if (addr_log.size() > 0) chk("abort_addr", addr_log[0], 64'd22);
        model_valid = 1'b0;
        do_fetch(5, 0);

        // Asynchronous reset while in RD2.
        start = 1'b1;
        idx   = 16'd9;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_reset("midreset");
        tick();
        rst_n = 1'b1;
        addr_log.delete();
        model_valid = 1'b0;
        tick();
        do_fetch(0, 1);

        // Randomized traffic with occasional repeats, bad indices and idle aborts.
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                model_valid = 1'b0;
            end
            if ($urandom_range(0, 7) == 0)
                t = NTREES + int'($urandom_range(0, 200));
            else if (model_valid && $urandom_range(0, 2) == 0)
                t = model_idx;
            else
                t = int'($urandom_range(0, NTREES - 1));
            do_fetch(t, int'($urandom_range(0, 3)));
        end

        repeat (3) tick();
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
